// File: rtl/mm_result_drain_pkg.sv
// Shared sizes and state encoding for the MM result drain.
package mm_result_drain_pkg;

  localparam int unsigned W       = 16;            // element width
  localparam int unsigned NWORDS  = 16;            // words per matrix (8 rows x 2 halves)
  localparam int unsigned WORD_W  = 4 * W;         // one word = 4 elements
  localparam int unsigned IDX_W   = $clog2(NWORDS);
  localparam int unsigned FRAME_W = 8;             // completed-matrix counter width

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

endpackage

// File: rtl/mm_result_bank.sv
// Snapshot register file: all words written together on load, one registered read port.
module mm_result_bank
  import mm_result_drain_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NWORDS*WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem_q [NWORDS];
  logic [WORD_W-1:0] rd_q;

  // Capture the whole matrix in one edge; contents need no reset.
  always_ff @(posedge clock) begin
    if (load) begin
      for (int k = 0; k < int'(NWORDS); k++) begin
        mem_q[k] <= wr_data[k*WORD_W +: WORD_W];
      end
    end
  end

  // Registered read of the next index; on a load word 0 bypasses the bank so the
  // first beat is ready one cycle after capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (load) begin
      rd_q <= wr_data[WORD_W-1:0];
    end else begin
      rd_q <= mem_q[rd_idx];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/mm_result_drain.sv
// Takes one finished 8x8 result matrix, snapshots it, and streams it row-major as 16 words.
module mm_result_drain
  import mm_result_drain_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [NWORDS*WORD_W-1:0] res_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic [FRAME_W-1:0]       frames
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NWORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frames_q, frames_d;

  logic beat_fire;
  logic final_fire;
  logic load;

  // State, beat index and frame counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
    end
  end

  // Next state: advance on accepted beats; the final beat may immediately reload.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (final_fire) begin
          frames_d = frames_q + 1'b1;
          idx_d    = '0;
          state_d  = load ? StStream : StIdle;
        end else if (beat_fire) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake outputs; res_ready opens combinationally on the accepted final beat so a
  // waiting matrix follows with no bubble.
  always_comb begin
    out_valid  = (state_q == StStream);
    out_last   = out_valid && (idx_q == LastIdx);
    beat_fire  = out_valid && out_ready;
    final_fire = beat_fire && out_last;
    res_ready  = (state_q == StIdle) || final_fire;
    load       = res_valid && res_ready;
    busy       = (state_q != StIdle);
    out_idx    = idx_q;
  end

  assign frames = frames_q;

  mm_result_bank u_bank (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .wr_data (res_data),
    .rd_idx  (idx_d),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_mm_result_drain.sv
// Randomized bench for mm_result_drain with a transaction-level reference model.
module tb_mm_result_drain;
  import mm_result_drain_pkg::*;

  localparam int MW = NWORDS * WORD_W;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [MW-1:0]      res_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WORD_W-1:0]  out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               busy;
  logic [FRAME_W-1:0] frames;

  int checks = 0;
  int errors = 0;

  // Reference model: the matrix being drained and how far along it is.
  bit                m_ok = 1'b0;
  bit                m_busy = 1'b0;
  int                m_idx = 0;
  int                m_frames = 0;
  logic [WORD_W-1:0] m_mat [NWORDS];

  always #5 clock = ~clock;

  mm_result_drain dut (
    .clock     (clock),
    .reset     (reset),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .frames    (frames)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Model update on each edge, using the inputs as they stood at the edge.
  always @(posedge clock) begin
    bit rr;
    if (reset) begin
      m_ok = 1'b1; m_busy = 1'b0; m_idx = 0; m_frames = 0;
    end else if (m_ok) begin
      rr = !m_busy || (m_idx == int'(NWORDS) - 1 && out_ready);
      if (m_busy && out_ready) begin
        if (m_idx == int'(NWORDS) - 1) begin
          m_frames++; m_busy = 1'b0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (res_valid && rr) begin
        for (int k = 0; k < int'(NWORDS); k++) m_mat[k] = res_data[k*WORD_W +: WORD_W];
        m_busy = 1'b1; m_idx = 0;
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clock) begin
    if (m_ok && !reset) begin
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("res_ready", 64'(res_ready),
          64'(!m_busy || (m_idx == int'(NWORDS) - 1 && out_ready)));
      chk("frames", 64'(frames), 64'(m_frames % 256));
      chk("out_idx", 64'(out_idx), 64'(m_idx));
      chk("out_last", 64'(out_last), 64'(m_busy && m_idx == int'(NWORDS) - 1));
      if (m_busy) chk("out_data", 64'(out_data), 64'(m_mat[m_idx]));
    end
  end

  // Present a matrix while idle; it is captured at the next edge.
  task automatic load(input logic [MW-1:0] m);
    res_valid = 1'b1;
    res_data  = m;
    @(posedge clock); #1;
    res_valid = 1'b0;
    res_data  = rand_mat();
  endtask

  task automatic wait_idle(input int bound, input bit stall);
    int n = 0;
    while (m_busy && n < bound) begin
      @(posedge clock); #1;
      n++;
      if (stall) out_ready = (n % 3 == 0);
    end
    chk("drain_timeout", 64'(m_busy), 64'(0));
    out_ready = 1'b1;
  endtask

  initial begin
    logic [MW-1:0] m;
    int n;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_res_ready", 64'(res_ready), 64'(1));
    chk("reset_out_data", 64'(out_data), 64'(0));

    // 1: known pattern, sink always ready
    for (int k = 0; k < int'(NWORDS); k++) m[k*WORD_W +: WORD_W] = {4{16'h0100 + 16'(k)}};
    out_ready = 1'b1;
    load(m);
    @(negedge clock);
    chk("t1_first_data", 64'(out_data), 64'h0100_0100_0100_0100);
    chk("t1_first_idx", 64'(out_idx), 64'(0));
    chk("t1_res_ready_low", 64'(res_ready), 64'(0));
    repeat (15) @(posedge clock);
    @(negedge clock);
    chk("t1_last_data", 64'(out_data), 64'h010f_010f_010f_010f);
    chk("t1_last", 64'(out_last), 64'(1));
    @(posedge clock); #1;
    @(negedge clock);
    chk("t1_busy_after", 64'(busy), 64'(0));
    chk("t1_frames", 64'(frames), 64'(1));

    // 2: stalling sink
    out_ready = 1'b1;
    load(rand_mat());
    wait_idle(200, 1'b1);

    // 3: back-to-back, B waiting when A's last beat is taken
    load(rand_mat());
    m = rand_mat();
    res_valid = 1'b1;
    res_data  = m;
    repeat (16) @(posedge clock);
    #1 res_valid = 1'b0;
    res_data = rand_mat();
    @(negedge clock);
    chk("t3_b_first_valid", 64'(out_valid), 64'(1));
    chk("t3_b_first_idx", 64'(out_idx), 64'(0));
    chk("t3_b_first_data", 64'(out_data), m[WORD_W-1:0]);
    wait_idle(40, 1'b0);
    chk("t3_frames", 64'(frames), 64'(4));

    // 4: res_valid pulse mid-drain is ignored
    load(rand_mat());
    repeat (7) @(posedge clock);
    #1 res_valid = 1'b1;
    res_data = rand_mat();
    @(negedge clock);
    chk("t4_res_ready_beat7", 64'(res_ready), 64'(0));
    @(posedge clock); #1;
    res_valid = 1'b0;
    wait_idle(40, 1'b0);
    chk("t4_frames", 64'(frames), 64'(5));

    // 5: reset at beat 9
    load(rand_mat());
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_frames", 64'(frames), 64'(0));
    chk("t5_res_ready", 64'(res_ready), 64'(1));
    load(rand_mat());
    wait_idle(40, 1'b0);
    chk("t5_frames_after", 64'(frames), 64'(1));

    // 6: random traffic until 257 frames, counter wraps to 1
    #0 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n = 0;
    while (!(m_frames == 257 && !m_busy) && n < 40000) begin
      out_ready = ($urandom_range(3) != 0);
      res_valid = ($urandom_range(1) == 1) && (m_frames + (m_busy ? 1 : 0) < 257);
      res_data  = rand_mat();
      @(posedge clock); #1;
      n++;
    end
    res_valid = 1'b0;
    out_ready = 1'b1;
    chk("t6_timeout", 64'(m_frames), 64'(257));
    @(negedge clock);
    chk("t6_frames_wrap", 64'(frames), 64'(1));
    chk("t6_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
